// File: rtl/plps_pkg.sv
// Shared definitions for the PL-PS capture path: FSM encoding, depth and
// local-bus register map used by the host driver.
package plps_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int unsigned ADDRWIDTH = 12;
    localparam int unsigned DEPTH     = 2 ** ADDRWIDTH;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_LEN    = 8'h04;
    localparam logic [7:0] REG_DECIM  = 8'h08;
    localparam logic [7:0] REG_STATUS = 8'h0C;

    localparam int unsigned CTRL_ARM_BIT       = 0;
    localparam int unsigned CTRL_ABORT_BIT     = 1;
    localparam int unsigned STATUS_BUSY_BIT    = 0;
    localparam int unsigned STATUS_DONE_BIT    = 1;
    localparam int unsigned STATUS_WRCOUNT_LSB = 16;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 2 ** aw;
    endfunction

endpackage

// File: rtl/decim_strobe.sv
// Decimation counter: runs 0..decim on each enabled beat, wraps to 0, and
// flags count 0 as the beat to keep.
module decim_strobe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] decim,
    output logic             keep
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == decim) ? '0 : cnt + WIDTH'(1);
        end
    end

    assign keep = (cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Captures a decimated block of one ADC AXI-stream lane into a BRAM after an
// external trigger, with host-visible busy/done/wr_count status.
module adc_capture_ctrl #(
    parameter int unsigned ADDRWIDTH  = 12,
    parameter int unsigned DATAWIDTH  = 64,
    parameter int unsigned DECIMWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig,
    input  logic [ADDRWIDTH-1:0]  len,
    input  logic [DECIMWIDTH-1:0] decim,
    input  logic [DATAWIDTH-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  bram_we,
    output logic [ADDRWIDTH-1:0]  bram_addr,
    output logic [DATAWIDTH-1:0]  bram_din,
    output logic                  busy,
    output logic                  done,
    output logic [ADDRWIDTH:0]    wr_count
);
    import plps_pkg::*;

    localparam logic [ADDRWIDTH:0] FULL_LEN = (ADDRWIDTH + 1)'(depth_of(ADDRWIDTH));
    localparam logic [ADDRWIDTH:0] ONE      = (ADDRWIDTH + 1)'(1);

    logic [1:0]            state, state_d;
    logic [ADDRWIDTH:0]    len_r;
    logic [DECIMWIDTH-1:0] decim_r;
    logic [ADDRWIDTH-1:0]  addr;
    logic                  keep, arm_ok, beat, wr_fire, last_wr;

    assign s_axis_tready = 1'b1;

    assign arm_ok  = arm && !abort && (state == ST_IDLE || state == ST_DONE);
    assign beat    = (state == ST_CAPTURE) && s_axis_tvalid && !abort;
    assign wr_fire = beat && keep;
    assign last_wr = wr_fire && ((wr_count + ONE) == len_r);

    decim_strobe #(
        .WIDTH (DECIMWIDTH)
    ) u_decim_strobe (
        .clk   (clk),
        .rst   (rst),
        .clr   (arm_ok),
        .en    (beat),
        .decim (decim_r),
        .keep  (keep)
    );

    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (arm)     state_d = ST_ARMED;
                ST_ARMED:         if (trig)    state_d = ST_CAPTURE;
                ST_CAPTURE:       if (last_wr) state_d = ST_DONE;
                default:                       state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_r     <= '0;
            decim_r   <= '0;
            addr      <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_count  <= '0;
        end else begin
            state   <= state_d;
            busy    <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            bram_we <= wr_fire;
            // done rises one cycle after the final write lands
            done    <= (state == ST_DONE) && !abort && !arm;
            if (wr_fire) begin
                bram_din  <= s_axis_tdata;
                bram_addr <= addr;
                addr      <= addr + ADDRWIDTH'(1);
                wr_count  <= wr_count + ONE;
            end
            if (arm_ok) begin
                len_r    <= (len == '0) ? FULL_LEN : {1'b0, len};
                decim_r  <= decim;
                addr     <= '0;
                wr_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a 16-word BRAM window.
module tb_adc_capture_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = 8;

    logic          clk, rst, arm, abort, trig;
    logic [AW-1:0] len;
    logic [MW-1:0] decim;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          busy, done;
    logic [AW:0]   wr_count;

    int n_checks = 0;
    int n_fails  = 0;

    adc_capture_ctrl #(
        .ADDRWIDTH  (AW),
        .DATAWIDTH  (DW),
        .DECIMWIDTH (MW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .abort         (abort),
        .trig          (trig),
        .len           (len),
        .decim         (decim),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .busy          (busy),
        .done          (done),
        .wr_count      (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each tick presents a fresh sample value for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        s_axis_tdata = s_axis_tdata + 64'd1;
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] dat;
        logic        v;
        int          n;

        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        len = '0; decim = '0; s_axis_tdata = 64'h100; s_axis_tvalid = 1'b0;

        // reset values
        tick(); tick();
        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_din", bram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrcount", wr_count, 0);
        chk("rst_tready", s_axis_tready, 1);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // 1: len=5, decim=0, continuous valid
        len = 4'd5; decim = 8'd0; s_axis_tvalid = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t1_armed_busy", busy, 1);
        chk("t1_armed_done", done, 0);
        tick(); tick();
        trig = 1'b1; tick(); trig = 1'b0;
        chk("t1_trig_cycle_we", bram_we, 0);
        base = s_axis_tdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_we", bram_we, 1);
            chk("t1_addr", bram_addr, 64'(i));
            chk("t1_din", bram_din, base + 64'(i));
        end
        chk("t1_last_wrcount", wr_count, 5);
        chk("t1_last_done", done, 0);
        chk("t1_last_busy", busy, 0);
        tick();
        chk("t1_end_we", bram_we, 0);
        chk("t1_end_done", done, 1);
        chk("t1_end_wrcount", wr_count, 5);

        // 2: len=4, decim=2 keeps beats 0,3,6,9
        len = 4'd4; decim = 8'd2;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t2_arm_clears_done", done, 0);
        trig = 1'b1; tick(); trig = 1'b0;
        base = s_axis_tdata;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t2_we", bram_we, (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0) begin
                chk("t2_addr", bram_addr, 64'(k / 3));
                chk("t2_din", bram_din, base + 64'(k));
            end
        end
        chk("t2_wrcount", wr_count, 4);
        tick();
        chk("t2_done", done, 1);

        // 3: len=0 means full 16-word depth, valid toggling
        len = 4'd0; decim = 8'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        n = 0;
        for (int c = 0; c < 32; c++) begin
            s_axis_tvalid = (c % 2 == 0);
            dat = s_axis_tdata;
            v = s_axis_tvalid;
            tick();
            chk("t3_we", bram_we, v);
            if (v) begin
                chk("t3_addr", bram_addr, 64'(n));
                chk("t3_din", bram_din, dat);
                n++;
            end
        end
        chk("t3_wrcount", wr_count, 16);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);

        // 4: abort after 3 writes of len=10, then restart
        s_axis_tvalid = 1'b1; len = 4'd10;
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        tick(); tick(); tick();
        chk("t4_pre_wrcount", wr_count, 3);
        chk("t4_pre_addr", bram_addr, 2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_abort_we", bram_we, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_wrcount", wr_count, 3);
        tick();
        chk("t4_idle_we", bram_we, 0);
        chk("t4_idle_wrcount", wr_count, 3);
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        base = s_axis_tdata;
        tick();
        chk("t4_restart_we", bram_we, 1);
        chk("t4_restart_addr", bram_addr, 0);
        chk("t4_restart_din", bram_din, base);
        chk("t4_restart_wrcount", wr_count, 1);
        abort = 1'b1; tick(); abort = 1'b0;

        // 5: arm during capture ignored; arm+abort in DONE goes idle
        len = 4'd3;
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        tick();
        len = 4'd8; arm = 1'b1; tick(); arm = 1'b0;
        chk("t5_mid_wrcount", wr_count, 2);
        chk("t5_mid_busy", busy, 1);
        tick();
        chk("t5_last_wrcount", wr_count, 3);
        chk("t5_last_busy", busy, 0);
        tick();
        chk("t5_done", done, 1);
        chk("t5_done_we", bram_we, 0);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("t5_armabort_done", done, 0);
        chk("t5_armabort_busy", busy, 0);
        tick();
        chk("t5_idle_busy", busy, 0);

        // 6: asynchronous reset mid-capture
        len = 4'd10;
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        tick(); tick();
        chk("t6_pre_we", bram_we, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_we", bram_we, 0);
        chk("t6_async_addr", bram_addr, 0);
        chk("t6_async_din", bram_din, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_done", done, 0);
        chk("t6_async_wrcount", wr_count, 0);
        chk("t6_async_tready", s_axis_tready, 1);
        #2 rst = 1'b0;
        trig = 1'b1; tick(); tick();
        chk("t6_trig_busy", busy, 0);
        chk("t6_trig_we", bram_we, 0);
        trig = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t6_rearm_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
